// File: rtl/dmem_responder.sv
// Data-memory responder: translates CPU byte addresses into a word array and
// answers loads/stores after a fixed number of wait states with a ready/err pulse.
//
// state | meaning
// IDLE  | waiting for ena && (DM_W || DM_R); latches the request
// WAIT  | counting down the configured wait states
// RESP  | one-cycle DM_ready pulse; array access happened on the entering edge
module dmem_responder #(
  parameter int          DEPTH_WORDS = 2048,
  parameter int          ADDR_W      = 11,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        DM_W,
  input  logic        DM_R,
  input  logic [1:0]  select,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic        DM_ready,
  output logic        DM_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]  CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;

  state_t state_q, state_d;
  logic [3:0]  cnt_q;
  logic        lat_w, lat_r, err_q;
  logic [1:0]  lat_sel;
  logic [31:0] lat_addr, lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic              req, enter_resp;
  logic              acc_w, acc_r, acc_err;
  logic [1:0]        acc_sel, lane;
  logic [31:0]       acc_addr, acc_wdata, off;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        lane_en, we;
  logic [31:0]       wdata_al, rd_shift, load_val;

  assign req = ena & (DM_W | DM_R);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) begin
        if (WAIT_CYCLES == 0) state_d = RESP;
        else                  state_d = WAIT;
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // With zero wait states the access happens on the accepting edge, so the
  // live inputs are used; otherwise the latched copy is.
  always_comb begin
    acc_w     = lat_w;
    acc_r     = lat_r;
    acc_sel   = lat_sel;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state_q == IDLE) begin
      acc_w     = DM_W;
      acc_r     = DM_R;
      acc_sel   = select;
      acc_addr  = DM_addr;
      acc_wdata = DM_wdata;
    end
  end

  assign off  = acc_addr - BASE_ADDR;
  assign idx  = off[ADDR_W+1:2];
  assign lane = off[1:0];

  assign acc_err = ({1'b0, off} >= SPAN)
                 | ((acc_sel == 2'b01) & off[0])
                 | ((acc_sel == 2'b00) & (off[1:0] != 2'b00))
                 | (acc_sel == 2'b11)
                 | (acc_w & acc_r);

  always_comb begin
    lane_en  = 4'b0000;
    wdata_al = acc_wdata;
    case (acc_sel)
      2'b00: lane_en = 4'b1111;
      2'b01: begin
        lane_en  = 4'b0011 << lane;
        wdata_al = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        lane_en  = 4'b0001 << lane;
        wdata_al = {4{acc_wdata[7:0]}};
      end
      default: lane_en = 4'b0000;
    endcase
  end

  assign we = (enter_resp && !reset && acc_w && !acc_err) ? lane_en : 4'b0000;

  assign rd_shift = mem[idx] >> {lane, 3'b000};

  always_comb begin
    case (acc_sel)
      2'b01:   load_val = {16'b0, rd_shift[15:0]};
      2'b10:   load_val = {24'b0, rd_shift[7:0]};
      default: load_val = mem[idx];
    endcase
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem[idx][8*k +: 8] <= wdata_al[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lat_w     <= 1'b0;
      lat_r     <= 1'b0;
      lat_sel   <= 2'b00;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      err_q     <= 1'b0;
      DM_rdata  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        lat_w     <= DM_W;
        lat_r     <= DM_R;
        lat_sel   <= select;
        lat_addr  <= DM_addr;
        lat_wdata <= DM_wdata;
        cnt_q     <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        err_q <= acc_err;
        if (acc_err)    DM_rdata <= 32'd0;
        else if (acc_r) DM_rdata <= load_val;
      end
    end
  end

  assign DM_ready = (state_q == RESP);
  assign DM_err   = (state_q == RESP) & err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with zero wait states and one
// with three, shared clock and reset.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ena0, w0, r0, ena3, w3, r3;
  logic [1:0]  sel0, sel3;
  logic [31:0] addr0, wdata0, addr3, wdata3;
  logic [31:0] rdata0, rdata3;
  logic        ready0, err0, busy0, ready3, err3, busy3;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .ena(ena0), .DM_W(w0), .DM_R(r0), .select(sel0),
    .DM_addr(addr0), .DM_wdata(wdata0), .DM_rdata(rdata0), .DM_ready(ready0),
    .DM_err(err0), .busy(busy0));

  dmem_responder #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .ena(ena3), .DM_W(w3), .DM_R(r3), .select(sel3),
    .DM_addr(addr3), .DM_wdata(wdata3), .DM_rdata(rdata3), .DM_ready(ready3),
    .DM_err(err3), .busy(busy3));

  // Called at #1 after an edge; returns what was seen in the response cycle.
  task automatic acc0(input logic w, input logic r, input logic [1:0] sel,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic rdy, output logic er, output logic [31:0] rd);
    ena0 = 1'b1; w0 = w; r0 = r; sel0 = sel; addr0 = a; wdata0 = wd;
    @(posedge clk); #1;
    rdy = ready0; er = err0; rd = rdata0;
    w0 = 1'b0; r0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic acc3(input logic w, input logic r, input logic [1:0] sel,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic er, output logic [31:0] rd);
    ena3 = 1'b1; w3 = w; r3 = r; sel3 = sel; addr3 = a; wdata3 = wd;
    lat = -1; er = 1'b0; rd = 32'd0;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk); #1;
      w3 = 1'b0; r3 = 1'b0;
      if (ready3) begin
        lat = k; er = err3; rd = rdata3;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ena0 = 0; w0 = 0; r0 = 0; sel0 = 0; addr0 = 0; wdata0 = 0;
    ena3 = 0; w3 = 0; r3 = 0; sel3 = 0; addr3 = 0; wdata3 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({ready0, err0, busy0, rdata0} !== 35'd0) begin
      errors++;
      $display("FAIL reset_u0 got rdy=%b err=%b busy=%b rdata=%h want all 0", ready0, err0, busy0, rdata0);
    end
    checks++;
    if ({ready3, err3, busy3, rdata3} !== 35'd0) begin
      errors++;
      $display("FAIL reset_u3 got rdy=%b err=%b busy=%b rdata=%h want all 0", ready3, err3, busy3, rdata3);
    end
  endtask

  task automatic test_word();
    logic rdy, er; logic [31:0] rd;
    acc0(1, 0, 2'b00, 32'h10010008, 32'hDEADBEEF, rdy, er, rd);
    checks++;
    if ({rdy, er} !== 2'b10) begin
      errors++; $display("FAIL store_word rdy/err=%b%b want 10", rdy, er);
    end
    acc0(0, 1, 2'b00, 32'h10010008, 32'h0, rdy, er, rd);
    checks++;
    if ({rdy, er} !== 2'b10 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_word rdy/err=%b%b rdata=%h want 10 deadbeef", rdy, er, rd);
    end
    checks++;
    if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL ready_one_cycle rdy=%b busy=%b want 0 0", ready0, busy0);
    end
    acc0(1, 0, 2'b00, 32'h10010000, 32'h11111111, rdy, er, rd);
    acc0(1, 0, 2'b00, 32'h10011FFC, 32'hA5A5C3C3, rdy, er, rd);
    acc0(0, 1, 2'b00, 32'h10011FFC, 32'h0, rdy, er, rd);
    checks++;
    if ({rdy, er} !== 2'b10 || rd !== 32'hA5A5C3C3) begin
      errors++; $display("FAIL last_word rdy/err=%b%b rdata=%h want 10 a5a5c3c3", rdy, er, rd);
    end
  endtask

  task automatic test_lanes();
    logic rdy, er; logic [31:0] rd;
    acc0(1, 0, 2'b10, 32'h1001000A, 32'hAAAAAA55, rdy, er, rd);
    acc0(1, 0, 2'b01, 32'h10010008, 32'hBBBB1234, rdy, er, rd);
    checks++;
    if (rd !== 32'hA5A5C3C3) begin
      errors++; $display("FAIL store_keeps_rdata rdata=%h want a5a5c3c3", rd);
    end
    acc0(0, 1, 2'b00, 32'h10010008, 32'h0, rdy, er, rd);
    checks++;
    if (rd !== 32'hDE551234 || er !== 1'b0) begin
      errors++; $display("FAIL lanes_word rdata=%h err=%b want de551234 0", rd, er);
    end
    acc0(0, 1, 2'b10, 32'h1001000B, 32'h0, rdy, er, rd);
    checks++;
    if (rd !== 32'h000000DE) begin
      errors++; $display("FAIL load_byte rdata=%h want 000000de", rd);
    end
    acc0(0, 1, 2'b01, 32'h1001000A, 32'h0, rdy, er, rd);
    checks++;
    if (rd !== 32'h0000DE55) begin
      errors++; $display("FAIL load_half rdata=%h want 0000de55", rd);
    end
  endtask

  task automatic test_errors();
    logic rdy, er; logic [31:0] rd;
    logic [1:0]  vsel [5] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b00};
    logic        vw   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vr   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] va   [5] = '{32'h10010009, 32'h10012000, 32'h10010008,
                              32'h10010008, 32'h1000FFFC};
    for (int i = 0; i < 5; i++) begin
      acc0(vw[i], vr[i], vsel[i], va[i], 32'hBAD0BAD0, rdy, er, rd);
      checks++;
      if ({rdy, er} !== 2'b11 || rd !== 32'h0) begin
        errors++; $display("FAIL err_case%0d rdy/err=%b%b rdata=%h want 11 0", i, rdy, er, rd);
      end
    end
    checks++;
    if (err0 !== 1'b0) begin
      errors++; $display("FAIL err_only_with_ready err=%b want 0", err0);
    end
    acc0(0, 1, 2'b00, 32'h10010008, 32'h0, rdy, er, rd);
    checks++;
    if (rd !== 32'hDE551234 || er !== 1'b0) begin
      errors++; $display("FAIL after_err_08 rdata=%h err=%b want de551234 0", rd, er);
    end
    acc0(0, 1, 2'b00, 32'h10010000, 32'h0, rdy, er, rd);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++; $display("FAIL after_err_00 rdata=%h want 11111111", rd);
    end
  endtask

  task automatic test_wait3();
    int lat; logic er; logic [31:0] rd;
    logic [9:0] busy_seen, rdy_seen;
    acc3(1, 0, 2'b00, 32'h10010000, 32'hCAFEF00D, lat, er, rd);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL wait3_store_latency got %0d want 4", lat);
    end
    busy_seen = '0; rdy_seen = '0;
    ena3 = 1; r3 = 1; w3 = 0; sel3 = 2'b00; addr3 = 32'h10010000;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      busy_seen[k] = busy3; rdy_seen[k] = ready3;
      if (ready3 && k == 4) rd = rdata3;
      if (k == 1 || k == 6) r3 = 0;
      if (k == 5) r3 = 1;
    end
    checks++;
    if (busy_seen !== 10'b11_1101_1110) begin
      errors++; $display("FAIL wait3_busy got %b want 1111011110", busy_seen);
    end
    checks++;
    if (rdy_seen !== 10'b10_0001_0000) begin
      errors++; $display("FAIL wait3_ready got %b want 1000010000", rdy_seen);
    end
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL wait3_rdata got %h want cafef00d", rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic er; logic [31:0] rd; int nrdy;
    ena3 = 1; w3 = 1; r3 = 0; sel3 = 2'b00; addr3 = 32'h10010000; wdata3 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    w3 = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    checks++;
    if (busy3 !== 1'b0 || ready3 !== 1'b0) begin
      errors++; $display("FAIL reset_mid_state busy=%b rdy=%b want 0 0", busy3, ready3);
    end
    nrdy = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ready3) nrdy++;
    end
    checks++;
    if (nrdy !== 0) begin
      errors++; $display("FAIL reset_mid_no_ready got %0d want 0", nrdy);
    end
    acc3(0, 1, 2'b00, 32'h10010000, 32'h0, lat, er, rd);
    checks++;
    if (lat !== 4 || rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL reset_mid_contents lat=%0d rdata=%h want 4 cafef00d", lat, rd);
    end
  endtask

  task automatic test_ena();
    int nrdy;
    logic [31:0] rd;
    ena0 = 0; r0 = 1; w0 = 0; sel0 = 2'b00; addr0 = 32'h10010008;
    nrdy = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ready0 || busy0) nrdy++;
    end
    checks++;
    if (nrdy !== 0) begin
      errors++; $display("FAIL ena_low_blocks got %0d active cycles want 0", nrdy);
    end
    ena0 = 1;
    nrdy = 0; rd = 32'd0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      ena0 = 0;
      if (ready0) begin nrdy++; rd = rdata0; end
    end
    r0 = 0;
    checks++;
    if (nrdy !== 1 || rd !== 32'hDE551234) begin
      errors++; $display("FAIL ena_pulse got %0d readies rdata=%h want 1 de551234", nrdy, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    ena0 = 1; r0 = 1; w0 = 0; sel0 = 2'b00; addr0 = 32'h10010008;
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      pat[k] = ready0;
    end
    r0 = 0;
    @(posedge clk); #1;
    checks++;
    if (pat !== 6'b010101) begin
      errors++; $display("FAIL back_to_back ready pattern %b want 010101", pat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_wait3();
    test_reset_mid();
    test_ena();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
